// File: rtl/norflash_16_if.sv
// Wishbone read-only bus bundle between the system interconnect and norflash_16.
`timescale 1ns/1ps

interface norflash_16_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_o;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic [3:0]  wb_sel_i;

  modport master (
    output wb_adr_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_cyc_i, wb_stb_i, wb_sel_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/norflash_16.sv
// Read-only Wishbone slave turning 32-bit reads into one or two timed 16-bit
// reads of an asynchronous NOR flash; high half comes from the even flash word.
`timescale 1ns/1ps

module norflash_16 #(
  parameter int adr_width = 22,
  parameter int rd_timing = 12
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  norflash_16_if.slave         wb,
  output logic [adr_width-1:0] flash_adr,
  inout  wire  [15:0]          flash_d,
  output logic                 flash_oe_n,
  output logic                 flash_we_n
);

  localparam int cnt_w = (rd_timing > 1) ? $clog2(rd_timing) : 1;
  localparam logic [cnt_w-1:0] cnt_load = cnt_w'(rd_timing - 1);

  typedef enum logic [1:0] {IDLE, READ_HI, READ_LO, ACK} state_t;

  state_t                 state, state_nxt;
  logic [cnt_w-1:0]       counter, counter_nxt;
  logic [adr_width-1:0]   adr_nxt;
  logic [31:0]            dat_q, dat_nxt;
  logic                   ack_q, ack_nxt;

  logic [adr_width-2:0]   word;
  logic                   need_hi, need_lo, req;
  logic                   unused_adr;

  assign word       = wb.wb_adr_i[adr_width:2];
  assign unused_adr = ^{wb.wb_adr_i[31:adr_width+1], wb.wb_adr_i[1:0]};
  assign need_hi    = |wb.wb_sel_i[3:2];
  assign need_lo    = |wb.wb_sel_i[1:0];
  // Gating on ack keeps a master that holds cyc/stb one edge past ack from retriggering.
  assign req        = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;

  assign wb.wb_dat_o = dat_q;
  assign wb.wb_ack_o = ack_q;
  assign flash_oe_n  = 1'b0;
  assign flash_we_n  = 1'b1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      counter   <= '0;
      flash_adr <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      counter   <= counter_nxt;
      flash_adr <= adr_nxt;
      dat_q     <= dat_nxt;
      ack_q     <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    adr_nxt     = flash_adr;
    dat_nxt     = dat_q;
    ack_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (need_hi) begin
            adr_nxt     = {word, 1'b0};
            counter_nxt = cnt_load;
            state_nxt   = READ_HI;
          end else if (need_lo) begin
            adr_nxt     = {word, 1'b1};
            counter_nxt = cnt_load;
            state_nxt   = READ_LO;
          end else begin
            ack_nxt   = 1'b1;
            state_nxt = ACK;
          end
        end
      end
      READ_HI: begin
        if (counter == '0) begin
          dat_nxt[31:16] = flash_d;
          if (need_lo) begin
            adr_nxt     = {word, 1'b1};
            counter_nxt = cnt_load;
            state_nxt   = READ_LO;
          end else begin
            ack_nxt   = 1'b1;
            state_nxt = ACK;
          end
        end else begin
          counter_nxt = counter - cnt_w'(1);
        end
      end
      READ_LO: begin
        if (counter == '0) begin
          dat_nxt[15:0] = flash_d;
          ack_nxt       = 1'b1;
          state_nxt     = ACK;
        end else begin
          counter_nxt = counter - cnt_w'(1);
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_norflash_16.sv
// Directed bench for norflash_16: flash model returns word address + 1 after 110 ns,
// and a transaction-level model predicts ack timing, read data and flash addresses.
`timescale 1ns/1ps

module tb_norflash_16;

  localparam int RD = 12;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [21:0] flash_adr;
  wire  [15:0] flash_d;
  logic        flash_oe_n;
  logic        flash_we_n;
  logic [15:0] flash_drv = 16'hDEAD;

  norflash_16_if bus ();

  norflash_16 #(.adr_width(22), .rd_timing(RD)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .wb         (bus),
    .flash_adr  (flash_adr),
    .flash_d    (flash_d),
    .flash_oe_n (flash_oe_n),
    .flash_we_n (flash_we_n)
  );

  always #5 sys_clk = ~sys_clk;

  // Asynchronous flash: data is garbage until 110 ns after the address last moved.
  time t_chg = 0;
  always @(flash_adr) t_chg = $time;
  always begin
    #1;
    flash_drv = (($time - t_chg) >= 110) ? 16'(flash_adr + 22'd1) : 16'hDEAD;
  end
  assign flash_d = flash_drv;

  int          errors = 0;
  int          checks = 0;
  int          edge_n = 0;
  int          exp_ack_edge = -1;
  bit          chk_en = 1'b0;
  logic [31:0] model_dat = '0;
  logic [21:0] model_fadr = '0;
  logic [21:0] prev_fadr = '0;
  logic [21:0] obs_q[$];
  logic [21:0] exp_q[$];

  always @(posedge sys_clk) edge_n++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (chk_en) begin
      check_output("ack", {31'd0, bus.wb_ack_o}, {31'd0, edge_n == exp_ack_edge});
      if (bus.wb_ack_o) check_output("rdata", bus.wb_dat_o, model_dat);
      check_output("oe_n", {31'd0, flash_oe_n}, 32'd0);
      check_output("we_n", {31'd0, flash_we_n}, 32'd1);
      if (flash_adr != prev_fadr) begin
        obs_q.push_back(flash_adr);
        prev_fadr = flash_adr;
      end
    end
  end

  task automatic model_expect(input logic [31:0] adr, input logic [3:0] sel, output int lat);
    logic [20:0] w;
    logic [21:0] a;
    w = adr[22:2];
    lat = 0;
    exp_q.delete();
    if (|sel[3:2]) begin
      a = {w, 1'b0};
      model_dat[31:16] = 16'(a + 22'd1);
      if (a != model_fadr) exp_q.push_back(a);
      model_fadr = a;
      lat += RD;
    end
    if (|sel[1:0]) begin
      a = {w, 1'b1};
      model_dat[15:0] = 16'(a + 22'd1);
      if (a != model_fadr) exp_q.push_back(a);
      model_fadr = a;
      lat += RD;
    end
  endtask

  task automatic check_flash_trace(input string name);
    check_output({name, "_flash_cnt"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check_output({name, "_flash_adr"}, {10'd0, obs_q[i]}, {10'd0, exp_q[i]});
    obs_q.delete();
  endtask

  // One full read: request, wait for ack, hold cyc/stb through the ack edge, idle a bit.
  task automatic apply_stimulus(input string name, input logic [31:0] adr, input logic [3:0] sel,
                                output int lat_meas, output logic [31:0] ack_dat);
    int lat;
    int cnt;
    model_expect(adr, sel, lat);
    @(negedge sys_clk); #1;
    bus.wb_adr_i = adr;
    bus.wb_sel_i = sel;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    exp_ack_edge = edge_n + 1 + lat;
    cnt = 0;
    do begin
      @(negedge sys_clk);
      cnt++;
    end while (!bus.wb_ack_o && cnt < 100);
    if (!bus.wb_ack_o) check_output({name, "_ack_timeout"}, 32'd0, 32'd1);
    lat_meas = cnt - 1;
    ack_dat  = bus.wb_dat_o;
    @(negedge sys_clk); #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    check_flash_trace(name);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    logic [31:0] d;
    sys_rst      = 1'b1;
    bus.wb_adr_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1 sys_rst = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_output("reset_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    check_output("reset_dat", bus.wb_dat_o, 32'd0);
    check_output("reset_fadr", {10'd0, flash_adr}, 32'd0);
    check_output("reset_oe_n", {31'd0, flash_oe_n}, 32'd0);
    check_output("reset_we_n", {31'd0, flash_we_n}, 32'd1);

    apply_stimulus("t2", 32'h0000FFF0, 4'b1111, lat, d);
    check_output("t2_lat", 32'(lat), 32'd24);
    check_output("t2_data", d, 32'h7FF97FFA);

    apply_stimulus("t3a", 32'h0000FFF0, 4'b0001, lat, d);
    check_output("t3a_lat", 32'(lat), 32'd12);
    check_output("t3a_lo", {16'd0, d[15:0]}, 32'h00007FFA);
    apply_stimulus("t3b", 32'h0000FFF1, 4'b0010, lat, d);
    check_output("t3b_lat", 32'(lat), 32'd12);

    apply_stimulus("t4a", 32'h0000FFF2, 4'b0100, lat, d);
    check_output("t4a_lat", 32'(lat), 32'd12);
    check_output("t4a_data", d, 32'h7FF97FFA);
    apply_stimulus("t4b", 32'h0000FFF3, 4'b1000, lat, d);
    apply_stimulus("t4c", 32'h0000FFF0, 4'b0100, lat, d);
    check_output("t4c_data", d, 32'h7FF97FFA);

    apply_stimulus("t5a", 32'h00000010, 4'b1111, lat, d);
    check_output("t5a_data", d, 32'h0009000A);
    apply_stimulus("t5b", 32'h00000040, 4'b1111, lat, d);
    check_output("t5b_data", d, 32'h00210022);

    apply_stimulus("sel0", 32'h00000080, 4'b0000, lat, d);
    check_output("sel0_lat", 32'(lat), 32'd0);
    check_output("sel0_data", d, 32'h00210022);

    // Reset in the middle of the high-half read must abort without an ack.
    model_expect(32'h00000100, 4'b1111, lat);
    @(negedge sys_clk); #1;
    bus.wb_adr_i = 32'h00000100;
    bus.wb_sel_i = 4'b1111;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    exp_ack_edge = edge_n + 1 + lat;
    repeat (5) @(negedge sys_clk);
    #1;
    sys_rst      = 1'b1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    exp_ack_edge = -1;
    model_dat    = '0;
    model_fadr   = '0;
    @(negedge sys_clk);
    check_output("t6_rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    check_output("t6_rst_dat", bus.wb_dat_o, 32'd0);
    check_output("t6_rst_fadr", {10'd0, flash_adr}, 32'd0);
    #1 sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);
    #1;
    obs_q.delete();
    apply_stimulus("t6", 32'h00000100, 4'b1111, lat, d);
    check_output("t6_lat", 32'(lat), 32'd24);
    check_output("t6_data", d, 32'h00810082);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
